// File: rtl/ripple_down_counter_pkg.sv
// Shared constants for the ripple down-counter and its T flip-flop stages.
// MAX_COUNT is the value the counter wraps to from zero at the default width.
package ripple_down_counter_pkg;

   localparam int DEFAULT_WIDTH = 3;
   localparam int MAX_COUNT     = (1 << DEFAULT_WIDTH) - 1;

   // Wrap target for an arbitrary counter width.
   function automatic int max_count(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/ripple_down_counter_t_ff.sv
// Rising-edge T flip-flop with asynchronous active-high clear.
// One instance of this module forms each stage of the ripple counter.
module t_ff (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q,
   output logic qbar
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else if (t) begin
         q <= ~q;
      end
   end

   assign qbar = ~q;

endmodule

// File: rtl/ripple_down_counter.sv
// Asynchronous (ripple) down-counter built from WIDTH T flip-flops, with a
// combinational zero decode and a clk-domain pulse marking each wrap-around.
module ripple_down_counter
   import ripple_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             zero,
   output logic             wrap
);

   logic [WIDTH-1:0] stage_q;
   logic [WIDTH-1:0] stage_qbar;
   logic [WIDTH-1:0] stage_clk;
   logic [WIDTH-1:0] stage_t;

   assign stage_clk[0] = clk;
   assign stage_t[0]   = en;

   // A stage borrows from the next one when it goes 0 -> 1, so each higher
   // stage is clocked by the rising edge of the true output below it.
   for (genvar i = 1; i < WIDTH; i++) begin : g_ripple_link
      assign stage_clk[i] = stage_q[i-1];
      assign stage_t[i]   = 1'b1;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      t_ff u_stage (
         .clk  (stage_clk[i]),
         .rst  (rst),
         .t    (stage_t[i]),
         .q    (stage_q[i]),
         .qbar (stage_qbar[i])
      );
   end

   assign Q    = stage_q;
   assign Qbar = stage_qbar;
   assign zero = ~|stage_q;

   // Only clk-domain consumer of the count: it sees the settled pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap <= 1'b0;
      end else begin
         wrap <= en && (stage_q == '0);
      end
   end

endmodule

// File: tb/tb_ripple_down_counter.sv
// Self-checking bench: drives 3-bit and 4-bit counters with the same stimulus
// and compares both against a modular-arithmetic model of the count.
module tb_ripple_down_counter;

   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] q3, qbar3;
   logic       zero3, wrap3;
   logic [3:0] q4, qbar4;
   logic       zero4, wrap4;

   int tests_run   = 0;
   int tests_fail  = 0;
   int model3      = 0;
   int model4      = 0;
   bit exp_wrap3   = 1'b0;
   bit exp_wrap4   = 1'b0;

   ripple_down_counter dut3 (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .Q    (q3),
      .Qbar (qbar3),
      .zero (zero3),
      .wrap (wrap3)
   );

   ripple_down_counter #(.WIDTH(4)) dut4 (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .Q    (q4),
      .Qbar (qbar4),
      .zero (zero4),
      .wrap (wrap4)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input int observed, input int expected);
      tests_run++;
      if (observed != expected) begin
         tests_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic check_output(input string tag);
      check_value({tag, "_q3"},    int'(q3),    model3);
      check_value({tag, "_qbar3"}, int'(qbar3), 7 - model3);
      check_value({tag, "_zero3"}, int'(zero3), int'(model3 == 0));
      check_value({tag, "_wrap3"}, int'(wrap3), int'(exp_wrap3));
      check_value({tag, "_q4"},    int'(q4),    model4);
      check_value({tag, "_qbar4"}, int'(qbar4), 15 - model4);
      check_value({tag, "_zero4"}, int'(zero4), int'(model4 == 0));
      check_value({tag, "_wrap4"}, int'(wrap4), int'(exp_wrap4));
   endtask

   // Called at a falling edge: one rising edge with the given enable, then check.
   task automatic apply_stimulus(input bit en_v, input string tag);
      en = en_v;
      @(posedge clk);
      exp_wrap3 = en_v && (model3 == 0);
      exp_wrap4 = en_v && (model4 == 0);
      if (en_v) begin
         model3 = (model3 + 8 - 1) % 8;
         model4 = (model4 + 16 - 1) % 16;
      end
      @(negedge clk);
      check_output(tag);
   endtask

   task automatic reset_model();
      model3    = 0;
      model4    = 0;
      exp_wrap3 = 1'b0;
      exp_wrap4 = 1'b0;
   endtask

   initial begin
      int last_wrap;
      int periods;
      rst = 1'b1;
      en  = 1'b0;
      #3;
      check_output("reset");
      @(negedge clk);
      rst = 1'b0;

      // Count from reset with en high: 7,6,...,0,7 and wraps on edges 1 and 9.
      for (int e = 1; e <= 9; e++) begin
         apply_stimulus(1'b1, "count");
         if (e == 1) begin
            check_value("first_edge_q3", int'(q3), 7);
            check_value("first_edge_q4", int'(q4), 15);
            check_value("first_edge_wrap3", int'(wrap3), 1);
         end
      end
      check_value("ninth_edge_q3", int'(q3), 7);

      apply_stimulus(1'b1, "to5");
      apply_stimulus(1'b1, "to5");
      check_value("at5_q3", int'(q3), 5);
      for (int e = 0; e < 4; e++) apply_stimulus(1'b0, "hold");
      check_value("hold_q3", int'(q3), 5);

      // Asynchronous reset between edges with the count at 3.
      apply_stimulus(1'b1, "to3");
      apply_stimulus(1'b1, "to3");
      check_value("pre_rst_q3", int'(q3), 3);
      #($urandom_range(1, 3));
      rst = 1'b1;
      #1;
      reset_model();
      check_output("async_rst");
      en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_output("rst_held");
      rst = 1'b0;

      // Sitting at zero with en low, then a single enabled edge.
      for (int e = 0; e < 3; e++) apply_stimulus(1'b0, "zero_hold");
      check_value("zero_hold_zero3", int'(zero3), 1);
      apply_stimulus(1'b1, "zero_leave");
      check_value("zero_leave_q3", int'(q3), 7);
      apply_stimulus(1'b0, "wrap_drop");

      // Randomised enable; every sample also confirms Qbar == ~Q.
      for (int e = 0; e < 40; e++) begin
         apply_stimulus(bit'($urandom_range(0, 3) != 0), "random");
      end

      // Wrap period of the 4-bit counter under continuous enable.
      last_wrap = -1;
      periods   = 0;
      for (int e = 0; e < 34; e++) begin
         apply_stimulus(1'b1, "period");
         if (wrap4) begin
            if (last_wrap >= 0) begin
               check_value("wrap_period4", e - last_wrap, 16);
               periods++;
            end
            last_wrap = e;
         end
      end
      check_value("wrap_period_seen4", int'(periods > 0), 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule

// File: doc/ripple_down_counter.md
RIPPLE_DOWN_COUNTER -- requirements
Module: ripple_down_counter

Interface
REQ-001 Parameter: WIDTH, default 3, number of ripple stages (counter width); legal range 2..8.
REQ-002 clk  input  1  system clock; clocks stage 0 and the wrap register, rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high; one clock (clk), one reset (rst).
REQ-004 en  input  1  count enable; sampled by stage 0 at rising clk.
REQ-005 Q  output  WIDTH  current count; Q[0] is the LSB.
REQ-006 Qbar  output  WIDTH  bitwise complement of Q.
REQ-007 zero  output  1  high while Q == 0; combinational decode of Q.
REQ-008 wrap  output  1  registered one-cycle pulse marking a 0 -> 2^WIDTH-1 transition.

Function
REQ-009 The counter SHALL count down by 1 on each rising clk edge with en = 1, modulo 2^WIDTH.
REQ-010 Stage 0 SHALL toggle on rising clk when en = 1 and hold when en = 0.
REQ-011 Stage i (i >= 1) SHALL toggle on each rising edge of Q[i-1] and SHALL NOT use clk (true ripple, down direction).
REQ-012 en SHALL affect stage 0 only; higher stages change only through the ripple.
REQ-013 Qbar SHALL equal ~Q at all times, including during reset.
REQ-014 zero SHALL be the NOR of Q; it MAY glitch during ripple settling and is valid once all stages have settled.
REQ-015 At each rising clk, wrap SHALL load 1 if en = 1 and the pre-edge Q == 0, else 0.
REQ-016 wrap SHALL be high for exactly one clk cycle per wrap-around.
REQ-017 Count sequence from 0 with en held high SHALL be 2^WIDTH-1, 2^WIDTH-2, ..., 1, 0, 2^WIDTH-1, ...
REQ-018 Holding en = 0 at count 0 SHALL keep Q = 0, zero = 1, wrap = 0.
REQ-019 The full ripple SHALL settle within one clk period; the count SHALL NOT be sampled by any clk-domain logic other than the wrap register.

Reset
REQ-020 rst = 1 SHALL force Q = 0, Qbar = all ones, zero = 1 and wrap = 0 immediately, independent of clk.
REQ-021 Reset asserted mid-count SHALL clear all stages at once, with no intermediate count values.
REQ-022 While rst = 1, clk edges and ripple edges SHALL have no effect.
REQ-023 The first enabled clk edge after rst deasserts SHALL move Q from 0 to 2^WIDTH-1 and set wrap = 1 for that cycle.

Structure
REQ-024 The design SHALL be structural: WIDTH instances of one sub-module, t_ff (T flip-flop: clk, rst, t, q, qbar; rising-edge, asynchronous active-high reset to q = 0).
REQ-025 Stage 0 SHALL use t = en and clock clk; stage i SHALL use t = 1 and clock Q[i-1].
REQ-026 The wrap register and the zero decode SHALL sit at the top level.
REQ-027 A shared package SHALL hold DEFAULT_WIDTH = 3 and the derived constant MAX_COUNT = 2^WIDTH-1; no typedefs are needed.

Verification
REQ-028 Reset and count: rst = 1 for 5 ns, then en = 1 for 9 edges -> Q = 7,6,5,4,3,2,1,0,7; wrap high after edges 1 and 9 only.
REQ-029 Hold: reach Q = 5, set en = 0 for 4 edges -> Q stays 5, zero = 0, wrap = 0.
REQ-030 Mid-count reset: assert rst between edges at Q = 3 -> Q = 0, Qbar = 7, zero = 1 at once, with no clk edge needed.
REQ-031 Zero decode: count to 0, then set en = 0 -> zero = 1 and stays 1; one enabled edge -> Q = 7, zero = 0, wrap = 1 for one cycle.
REQ-032 Complement check: at every settled sample over 20 cycles, Qbar == ~Q.
REQ-033 Parameter sweep: WIDTH = 4 with en = 1 from reset -> Q = 15 after edge 1; wrap period = 16 edges.
